// File: rtl/pwm_gen.sv
// pwm_gen: prescaled edge/center-aligned PWM whose settings are double-buffered through a shadow
// register set and only become active at a period boundary (or at once while disabled).
module pwm_gen #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic             center,
    input  logic             load,
    output logic             load_ack,
    output logic             pwm_out,
    output logic             period_end,
    output logic [CNT_W-1:0] counter_out
);
    logic [DIV_W-1:0] pre_cnt, div_a, div_s;
    logic [CNT_W-1:0] cnt, per_a, per_s, duty_a, duty_s, cnt_inc, cnt_dec, cnt_nxt;
    logic center_a, center_s, dir, dir_nxt, pending;
    logic tick, boundary, load_now, xfer;

    always_comb begin
        cnt_inc = cnt + CNT_W'(1);
        cnt_dec = cnt - CNT_W'(1);
        tick = enable && pre_cnt == div_a;
        boundary = tick && (center_a ? (per_a == '0 || (dir && cnt == CNT_W'(1))) : cnt == per_a);
        load_now = boundary && load;
        xfer = load_now || (pending && (!enable || boundary));
        cnt_nxt = boundary ? '0 : dir ? cnt_dec : cnt_inc;
        // dir marks the down slope; it is set on arriving at the top and cleared on returning to 0
        dir_nxt = !boundary && center_a && (dir ? cnt != CNT_W'(1) : cnt_inc == per_a);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            cnt <= '0;
            dir <= 1'b0;
            div_a <= '0;
            per_a <= '0;
            duty_a <= '0;
            center_a <= 1'b0;
            div_s <= '0;
            per_s <= '0;
            duty_s <= '0;
            center_s <= 1'b0;
            pending <= 1'b0;
            load_ack <= 1'b0;
            pwm_out <= 1'b0;
            period_end <= 1'b0;
        end else begin
            pre_cnt <= (!enable || tick) ? '0 : pre_cnt + DIV_W'(1);
            if (!enable) begin
                cnt <= '0;
                dir <= 1'b0;
            end else if (tick) begin
                cnt <= cnt_nxt;
                dir <= dir_nxt;
            end
            if (load) begin
                div_s <= div_val;
                per_s <= period;
                duty_s <= duty;
                center_s <= center;
            end
            if (xfer) begin
                div_a <= load_now ? div_val : div_s;
                per_a <= load_now ? period : per_s;
                duty_a <= load_now ? duty : duty_s;
                center_a <= load_now ? center : center_s;
            end
            pending <= load ? !load_now : pending && !xfer;
            load_ack <= xfer;
            pwm_out <= enable && cnt < duty_a;
            period_end <= boundary;
        end
    end

    assign counter_out = cnt;
endmodule
